// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Holds the frame FSM states, the parity modes and the data-bit decoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } uart_parity_e;

    function automatic logic [3:0] data_bits_n(input logic [1:0] sel);
        return 4'd5 + {2'b00, sel};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] sel);
        case (sel)
            2'd0:    return 8'h1F;
            2'd1:    return 8'h3F;
            2'd2:    return 8'h7F;
            default: return 8'hFF;
        endcase
    endfunction

    // Encoding 3 is treated as "no parity", the same as 0.
    function automatic uart_parity_e parity_sel(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmitter; read data is valid while not empty.
// Pointers carry one extra wrap bit so that full and empty are distinguishable.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign level   = wptr_q - rptr_q;
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + LVL_W'(1);
            if (do_pop)  rptr_q <= rptr_q + LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: FIFO-buffered bytes framed as start,
// 5-8 data bits LSB first, optional parity and 1 or 2 stop bits.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD_RATE   = 19200,
    parameter int DIV_W       = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = CLK_FREQ / BAUD_RATE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic                          tx,
    output logic                          tx_active,
    output logic                          done_tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    function automatic logic [DIV_W-1:0] bit_period(input logic [DIV_W-1:0] div);
        logic [DIV_W-1:0] p;
        p = (div == '0) ? DEF_DIV : div;
        if (p == '0) p = ONE;
        return p;
    endfunction

    logic [7:0]     fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;

    uart_tx_state_e state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [2:0]     idx_q, idx_d;
    logic [2:0]     nlast_q, nlast_d;
    logic [7:0]     data_q, data_d;
    uart_parity_e   par_q, par_d;
    logic           stop2_q, stop2_d;
    logic           stop_second_q, stop_second_d;
    logic           line_d;
    logic [3:0]     nbits;
    logic           tx_q;
    logic           active_q;
    logic           done_q;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign in_ready  = !fifo_full;
    assign tx        = tx_q;
    assign tx_active = active_q;
    assign done_tx   = done_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        per_d         = per_q;
        idx_d         = idx_q;
        nlast_d       = nlast_q;
        data_d        = data_q;
        par_d         = par_q;
        stop2_d       = stop2_q;
        stop_second_d = stop_second_q;
        fifo_pop      = 1'b0;
        line_d        = 1'b1;
        nbits         = data_bits_n(cfg_data_bits);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // Config is captured together with the word so a frame never changes shape.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_rdata & data_mask(cfg_data_bits);
                    nlast_d  = 3'(nbits - 4'd1);
                    par_d    = parity_sel(cfg_parity);
                    stop2_d  = cfg_stop2;
                    per_d    = bit_period(cfg_div);
                    cnt_d    = bit_period(cfg_div) - ONE;
                    state_d  = START;
                end
            end
            START: begin
                line_d = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = per_q - ONE;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            DATA: begin
                line_d = data_q[idx_q];
                if (cnt_q == '0) begin
                    cnt_d = per_q - ONE;
                    if (idx_q == nlast_q) begin
                        stop_second_d = 1'b0;
                        state_d       = (par_q == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            PARITY: begin
                // Bits above N were masked at latch time, so the full-byte XOR is exact.
                line_d = (^data_q) ^ (par_q == PAR_ODD);
                if (cnt_q == '0) begin
                    cnt_d         = per_q - ONE;
                    stop_second_d = 1'b0;
                    state_d       = STOP;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            STOP: begin
                line_d = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d = per_q - ONE;
                    if (stop2_q && !stop_second_q) begin
                        stop_second_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            stop_second_q <= 1'b0;
            tx_q          <= 1'b1;
            active_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            stop_second_q <= stop_second_d;
            tx_q          <= line_d;
            active_q      <= (state_q == START) || (state_q == DATA) ||
                             (state_q == PARITY) || (state_q == STOP);
            done_q        <= (state_q == DONE);
        end
    end

    always_ff @(posedge clk) begin
        per_q   <= per_d;
        nlast_q <= nlast_d;
        data_q  <= data_d;
        par_q   <= par_d;
        stop2_q <= stop2_d;
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a frame-level waveform model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_cfg;

    localparam int DEPTH  = 8;
    localparam int DEFDIV = 6;
    localparam int DIV_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DIV_W-1:0]  cfg_div;
    logic [1:0]        cfg_data_bits;
    logic [1:0]        cfg_parity;
    logic              cfg_stop2;
    logic              tx;
    logic              tx_active;
    logic              done_tx;
    logic [3:0]        fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .DIV_W       (DIV_W),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (DEFDIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx            (tx),
        .tx_active     (tx_active),
        .done_tx       (done_tx),
        .fifo_level    (fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of (tx, active, done) values the outputs must take after successive edges.
    typedef struct packed { logic tx; logic act; logic done; } out_t;
    localparam out_t IDLE_OUT = '{tx: 1'b1, act: 1'b0, done: 1'b0};

    out_t       seq[$];
    logic [7:0] mfifo[$];
    out_t       m_out = IDLE_OUT;
    int         m_level = 0;
    logic       m_ready = 1'b1;
    bit         m_valid = 0;

    function automatic void build_frame(input logic [7:0] d);
        int   p;
        int   n;
        logic par;
        logic bits[$];
        p   = (cfg_div == 0) ? DEFDIV : int'(cfg_div);
        n   = int'(cfg_data_bits) + 5;
        par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            par ^= d[i];
        end
        if (cfg_parity == 2'd1) bits.push_back(par);
        if (cfg_parity == 2'd2) bits.push_back(~par);
        bits.push_back(1'b1);
        if (cfg_stop2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < p; k++) seq.push_back('{tx: bits[i], act: 1'b1, done: 1'b0});
        end
        seq.push_back('{tx: 1'b1, act: 1'b0, done: 1'b1});
    endfunction

    always @(posedge clk) begin : model
        out_t cur;
        bit   can_push;
        if (!rst_n) begin
            seq.delete();
            mfifo.delete();
            m_out   = IDLE_OUT;
            m_level = 0;
            m_ready = 1'b1;
            m_valid = 1;
        end else begin
            can_push = in_valid && (mfifo.size() < DEPTH);
            cur = (seq.size() > 0) ? seq.pop_front() : IDLE_OUT;
            if (!cur.act && seq.size() == 0 && mfifo.size() > 0) build_frame(mfifo.pop_front());
            if (can_push) mfifo.push_back(in_data);
            m_out   = cur;
            m_level = mfifo.size();
            m_ready = (m_level < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("tx", tx, m_out.tx);
            check("tx_active", tx_active, m_out.act);
            check("done_tx", done_tx, m_out.done);
            check("in_ready", in_ready, m_ready);
            check("fifo_level", fifo_level, m_level);
        end
    end

    // Frame capture: tx while active, closed by done_tx, discarded on an abort.
    logic       fr[$];
    logic       last_frame[$];
    int         frame_len_q[$];
    logic [7:0] rx_q[$];
    int         frames_done = 0;
    int         cur_p = 4;
    int         cur_n = 8;

    always @(negedge clk) begin
        logic [7:0] b;
        if (tx_active === 1'b1) begin
            fr.push_back(tx);
        end else if (done_tx === 1'b1) begin
            last_frame = fr;
            frame_len_q.push_back(fr.size());
            b = 8'h00;
            for (int i = 0; i < cur_n; i++) begin
                if ((1 + i) * cur_p < fr.size()) b[i] = fr[(1 + i) * cur_p];
            end
            rx_q.push_back(b);
            frames_done++;
            fr.delete();
        end else begin
            fr.delete();
        end
    end

    task automatic push(input logic [7:0] b);
        int t;
        t        = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            errors++;
            $display("FAIL push_timeout: in_ready stayed low, required 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t;
        t = 0;
        while (frames_done < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("frames_done", frames_done, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not end, required finish");
        $fatal(1, "timeout");
    end

    logic [7:0] words[9];
    int         exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int         base;
    int         d0;

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = 8'h00;
        cfg_div       = 16'd4;
        cfg_data_bits = 2'd3;
        cfg_parity    = 2'd0;
        cfg_stop2     = 1'b0;

        // Reset idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_done", done_tx, 0);

        // 8N1 frame, P=4
        cur_p = 4; cur_n = 8;
        push(8'hA5);
        wait_frames(1, 200);
        check("a5_len", frame_len_q[frame_len_q.size() - 1], 40);
        for (int b = 0; b < 10; b++) check("a5_bit", last_frame[b * 4 + 2], exp_a5[b]);
        check("a5_rx", rx_q[rx_q.size() - 1], 8'hA5);

        // 7E1 then 7O2, P=2, byte 0x55 has four ones in its low 7 bits
        cfg_div = 16'd2; cfg_data_bits = 2'd2; cfg_parity = 2'd1;
        cur_p = 2; cur_n = 7;
        push(8'h55);
        wait_frames(2, 200);
        check("even_len", frame_len_q[frame_len_q.size() - 1], 20);
        check("even_par", last_frame[17], 0);
        cfg_parity = 2'd2; cfg_stop2 = 1'b1;
        push(8'h55);
        wait_frames(3, 200);
        check("odd_len", frame_len_q[frame_len_q.size() - 1], 22);
        check("odd_par", last_frame[17], 1);
        check("stop2_a", last_frame[18], 1);
        check("stop2_b", last_frame[21], 1);
        check("odd_rx", rx_q[rx_q.size() - 1], 8'h55);

        // Back-to-back with the FIFO filled, P=1
        cfg_div = 16'd1; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        cur_p = 1; cur_n = 8;
        base = frames_done;
        rx_q.delete();
        for (int i = 0; i < 9; i++) begin
            words[i] = 8'h3C ^ 8'(i * 37);
            push(words[i]);
        end
        check("full_level", fifo_level, 8);
        check("full_ready", in_ready, 0);
        wait_frames(base + 9, 600);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) check("b2b_rx", rx_q[i], words[i]);
            else check("b2b_rx_missing", rx_q.size(), 9);
        end

        // Divisor changed mid-frame applies to the next frame only
        cfg_div = 16'd4;
        base = frames_done;
        push(8'h11);
        push(8'h22);
        repeat (10) @(negedge clk);
        check("midcfg_active", tx_active, 1);
        cfg_div = 16'd8;
        wait_frames(base + 2, 400);
        check("midcfg_len1", frame_len_q[frame_len_q.size() - 2], 40);
        check("midcfg_len2", frame_len_q[frame_len_q.size() - 1], 80);
        cfg_div = 16'd0;
        push(8'h33);
        wait_frames(base + 3, 400);
        check("default_len", frame_len_q[frame_len_q.size() - 1], 10 * DEFDIV);

        // Reset mid-frame aborts and flushes
        cfg_div = 16'd4;
        push(8'h5A);
        push(8'h77);
        repeat (12) @(negedge clk);
        check("abort_active", tx_active, 1);
        d0 = frames_done;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_tx", tx, 1);
        check("abort_act", tx_active, 0);
        check("abort_level", fifo_level, 0);
        check("abort_done", done_tx, 0);
        repeat (60) @(negedge clk);
        check("abort_no_done", frames_done, d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter with an input FIFO; successor to the fixed 8N1 transmitter. Accepts bytes over a valid/ready handshake, buffers up to `FIFO_DEPTH` words, and serialises each as a frame: start bit, 5–8 data bits LSB first, optional even/odd parity, then 1 or 2 stop bits, at a runtime-programmable bit period. Sits between the register/host side and the `tx` pad.

## Interface
Parameters:
- `CLK_FREQ`, 50000000: system clock in Hz, used only for `DEFAULT_DIV`.
- `BAUD_RATE`, 19200: used only for `DEFAULT_DIV`.
- `DIV_W`, 16: width of the bit-period divisor.
- `FIFO_DEPTH`, 8: input FIFO entries; a power of 2 and at least 2.
- `DEFAULT_DIV`, `CLK_FREQ/BAUD_RATE`: the bit period used when `cfg_div` is 0.

Ports:
- `clk` input 1: the single clock. All logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_data` input 8: byte to transmit.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the FIFO is not full. Driven from registered state only.
- `cfg_div` input DIV_W: clocks per bit. 0 selects `DEFAULT_DIV`.
- `cfg_data_bits` input 2: number of data bits; 0→5, 1→6, 2→7, 3→8.
- `cfg_parity` input 2: 0 none, 1 even, 2 odd, 3 none.
- `cfg_stop2` input 1: 1 selects two stop bits.
- `tx` output 1: serial line, registered, idle high.
- `tx_active` output 1: high from the first start-bit cycle through the last stop-bit cycle.
- `done_tx` output 1: one-cycle pulse after each frame completes.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.

## Operation
- **Reset** (`rst_n`=0 at an edge): next cycle `tx`=1, `tx_active`=0, `done_tx`=0, `in_ready`=1, `fifo_level`=0. The FIFO is flushed and the FSM returns to IDLE. Reset mid-frame aborts the frame immediately and the line goes high.
- **Push:** occurs when `in_valid && in_ready`. A push while full is impossible because `in_ready`=0. A push and a pop in the same cycle leave `fifo_level` unchanged. When full, `in_ready` stays 0 in a push+pop cycle and rises the cycle after the pop.
- **Config latch:** the `cfg_*` inputs are sampled only when a word is popped and are held for the whole frame. Changing them mid-frame has no effect on that frame.
- **Bit period:** P = (`cfg_div`==0 ? `DEFAULT_DIV` : `cfg_div`) clocks, with a minimum of 1. A down-counter of DIV_W bits reloads to P-1 at each bit boundary.
- **FSM states** (enum in package): IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop, latch the data and config, and go to START.
  - START: `tx`=0 for P cycles, then go to DATA with bit index 0.
  - DATA: `tx`=data[idx] for P cycles. After the last bit (idx = N-1), go to PARITY if parity is enabled, otherwise go to STOP.
  - PARITY: `tx` is the XOR of the N data bits for even parity, or its inverse for odd. It is driven for P cycles.
  - STOP: `tx`=1 for P cycles, or 2P cycles when `cfg_stop2` is set, then go to DONE.
  - DONE: for 1 cycle, `done_tx`=1 and `tx`=1. If the FIFO is non-empty, pop and go straight to START; otherwise go to IDLE.
- Data bits at or above N are ignored; no error is raised.

## Timing
- **Idle latency:** an empty FIFO and IDLE state, with a push at edge 0, gives `fifo_level`=1 after edge 0. The pop happens at edge 1, and `tx`=0 and `tx_active`=1 take effect after edge 2.
- **Frame length:** (1 + N + parity + stop bits) × P cycles of `tx_active`=1.
- **Back-to-back frames:** exactly one high cycle (DONE) separates the last stop-bit cycle from the next start bit.
- `done_tx` is asserted in the cycle immediately after the final stop-bit cycle. `tx_active` is 0 in that cycle.
- `tx` is registered, so no combinational path exists from any input to `tx`.

## Structure
- Package `uart_pkg`:
  - `uart_tx_state_e` enum.
  - `uart_parity_e` enum: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - A function mapping `cfg_data_bits` to N.
- Sub-module `uart_tx_fifo`:
  - Synchronous FIFO with parameters WIDTH=8 and DEPTH.
  - Ports: push/pop/full/empty/level, same clock and reset.
  - Read data is valid combinationally while not empty.
- The top level holds the FSM, the divider counter, the bit index and the latched config.

## Test plan
- **Reset idle:** hold `rst_n`=0 for 3 cycles, then release → `tx`=1, `in_ready`=1, `fifo_level`=0, `done_tx`=0.
- **8N1 frame:** `cfg_div`=4, 8N1, push 0xA5 → `tx` reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `tx_active` lasts 40 cycles, and `done_tx` is one pulse 1 cycle later.
- **Parity:** `cfg_div`=2, 7 data bits, push 0x55 → even parity bit 0, odd parity bit 1. With `cfg_stop2`=1 the stop level holds for 4 cycles.
- **Back-to-back and full FIFO:** `cfg_div`=1, push 9 words with `FIFO_DEPTH`=8.
  - `in_ready` drops when `fifo_level`=8 and recovers after the first pop.
  - All 9 frames are sent in order, separated by 1 high cycle each.
- **Config change mid-frame:** change `cfg_div` from 4 to 8 during the DATA state → the current frame stays at P=4 and the next frame uses P=8. With `cfg_div`=0, P = `DEFAULT_DIV`.
- **Reset mid-frame:** assert `rst_n`=0 during the DATA state → `tx`=1, `tx_active`=0, `fifo_level`=0 next cycle, and no `done_tx` pulse.
